// File: rtl/pwm_counter_bank.sv
// pwm_counter_bank: shared W-bit PWM timebase (sawtooth or triangle,
// continuous or one-shot) driving NUM_CH registered compare outputs.
// Optional build macro PWM_CNT_SHADOW_EN: period and compare values are
// latched into shadow registers on clear, on every zero event and while
// halted, so mid-period writes only take effect at a period boundary.
// Interface: there is no valid/ready handshake; every output is a plain
// register updated on each rising clk edge.
module pwm_counter_bank #(
  parameter int NUM_CNT_BITS = 8,
  parameter int NUM_CH       = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           clear,
  input  logic                           count_enable,
  input  logic                           up_down,
  input  logic                           one_shot,
  input  logic [NUM_CNT_BITS-1:0]        period,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] cmp,
  input  logic [NUM_CH-1:0]              invert,
  output logic [NUM_CNT_BITS-1:0]        count_out,
  output logic                           dir_up,
  output logic                           zero_flag,
  output logic                           top_flag,
  output logic                           done,
  output logic [NUM_CH-1:0]              pwm_out
);

  localparam int W = NUM_CNT_BITS;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0]        count_q, count_d;
  logic                dir_up_q, dir_up_d;
  logic                done_q, done_d;
  logic                zero_flag_q, zero_flag_d;
  logic                top_flag_q, top_flag_d;
  logic [NUM_CH-1:0]   pwm_q, pwm_d;

  // Active period / compare seen by the step logic.
  logic [W-1:0]        period_act;
  logic [NUM_CH*W-1:0] cmp_act;

  // Result of one counting step from the current state.
  logic [W-1:0]        step_count;
  logic                step_dir;
  logic                step_zero;
  logic [NUM_CH-1:0]   step_raw;
  logic [NUM_CH-1:0]   clear_raw;

`ifdef PWM_CNT_SHADOW_EN
  logic [W-1:0]        period_sh_q, period_sh_d;
  logic [NUM_CH*W-1:0] cmp_sh_q, cmp_sh_d;
  logic                load_shadow;

  // Shadow reload points: restart, period boundary, or while halted.
  always_comb begin
    load_shadow = clear | done_q | (count_enable & step_zero);
    period_sh_d = load_shadow ? period : period_sh_q;
    cmp_sh_d    = load_shadow ? cmp : cmp_sh_q;
  end

  // Shadow registers, cleared to 0 on reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      period_sh_q <= '0;
      cmp_sh_q    <= '0;
    end else begin
      period_sh_q <= period_sh_d;
      cmp_sh_q    <= cmp_sh_d;
    end
  end

  assign period_act = period_sh_q;
  assign cmp_act    = cmp_sh_q;
`else
  assign period_act = period;
  assign cmp_act    = cmp;
`endif

  // Next count/direction for one step; >= / < comparisons keep the counter
  // wrapping cleanly when the period is lowered below the current count.
  always_comb begin
    step_count = count_q;
    step_dir   = dir_up_q;
    step_zero  = 1'b0;
    if (!up_down) begin
      step_dir = 1'b1;
      if (count_q >= period_act) begin
        step_count = '0;
        step_zero  = 1'b1;
      end else begin
        step_count = count_q + ONE;
      end
    end else if (dir_up_q) begin
      if (period_act == '0) begin
        step_count = '0;
        step_zero  = 1'b1;
      end else if (count_q < period_act) begin
        step_count = count_q + ONE;
      end else if (count_q == ONE) begin
        // Reversal lands directly on 0 (P=1 triangle): a zero event, stay up.
        step_count = '0;
        step_zero  = 1'b1;
      end else begin
        step_count = count_q - ONE;
        step_dir   = 1'b0;
      end
    end else begin
      if (count_q <= ONE) begin
        step_count = '0;
        step_zero  = 1'b1;
        step_dir   = 1'b1;
      end else begin
        step_count = count_q - ONE;
      end
    end
  end

  // Per-channel raw compare for a step and for a restart at count 0.
  always_comb begin
    step_raw  = '0;
    clear_raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      step_raw[i]  = step_count < cmp_act[i*W +: W];
      clear_raw[i] = cmp[i*W +: W] != '0;
    end
  end

  // Priority: clear, then an enabled step while not halted, else hold.
  always_comb begin
    count_d     = count_q;
    dir_up_d    = dir_up_q;
    done_d      = done_q;
    zero_flag_d = 1'b0;
    top_flag_d  = 1'b0;
    pwm_d       = pwm_q;
    if (clear) begin
      count_d  = '0;
      dir_up_d = 1'b1;
      done_d   = 1'b0;
      pwm_d    = clear_raw ^ invert;
    end else if (count_enable && !done_q) begin
      count_d     = step_count;
      dir_up_d    = step_dir;
      zero_flag_d = step_zero;
      top_flag_d  = step_count == period_act;
      done_d      = step_zero & one_shot;
      pwm_d       = step_raw ^ invert;
    end
  end

  // State registers; reset drives pwm_out to the sampled polarity.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q     <= '0;
      dir_up_q    <= 1'b1;
      done_q      <= 1'b0;
      zero_flag_q <= 1'b0;
      top_flag_q  <= 1'b0;
      pwm_q       <= invert;
    end else begin
      count_q     <= count_d;
      dir_up_q    <= dir_up_d;
      done_q      <= done_d;
      zero_flag_q <= zero_flag_d;
      top_flag_q  <= top_flag_d;
      pwm_q       <= pwm_d;
    end
  end

  assign count_out = count_q;
  assign dir_up    = dir_up_q;
  assign done      = done_q;
  assign zero_flag = zero_flag_q;
  assign top_flag  = top_flag_q;
  assign pwm_out   = pwm_q;

endmodule

// File: tb/tb_pwm_counter_bank.sv
// Bench for pwm_counter_bank: directed sequences then random stimulus,
// each cycle's expected outputs come from a behavioural model and are
// queued; a monitor pops and compares one entry per clock edge.
module tb_pwm_counter_bank;

  localparam int W      = 8;
  localparam int NUM_CH = 4;
  localparam int EW     = W + 4 + NUM_CH;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                n_rst = 1'b0;
  logic                clear = 1'b0;
  logic                count_enable = 1'b0;
  logic                up_down = 1'b0;
  logic                one_shot = 1'b0;
  logic [W-1:0]        period = '0;
  logic [NUM_CH*W-1:0] cmp = '0;
  logic [NUM_CH-1:0]   invert = '0;
  logic [W-1:0]        count_out;
  logic                dir_up, zero_flag, top_flag, done;
  logic [NUM_CH-1:0]   pwm_out;

  always #5 clk = ~clk;

  pwm_counter_bank #(.NUM_CNT_BITS(W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable),
    .up_down(up_down), .one_shot(one_shot), .period(period), .cmp(cmp),
    .invert(invert), .count_out(count_out), .dir_up(dir_up),
    .zero_flag(zero_flag), .top_flag(top_flag), .done(done), .pwm_out(pwm_out)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // ---------------- behavioural model ----------------
  int                m_count = 0;
  bit                m_dir = 1'b1;
  bit                m_done = 1'b0;
  bit                m_zero = 1'b0;
  bit                m_top = 1'b0;
  logic [NUM_CH-1:0] m_pwm = '0;
  int                m_per = 0;
  int                m_cmp[NUM_CH];

  task automatic model_step(input logic rst, input logic clr, input logic en,
                            input logic ud, input logic os,
                            input logic [W-1:0] per,
                            input logic [NUM_CH*W-1:0] cv,
                            input logic [NUM_CH-1:0] inv);
    int p;
    int c[NUM_CH];
    int nxt;
    bit zev;
    bit ndir;
    bit reload;
`ifdef PWM_CNT_SHADOW_EN
    p = m_per;
    for (int i = 0; i < NUM_CH; i++) c[i] = m_cmp[i];
`else
    p = int'(per);
    for (int i = 0; i < NUM_CH; i++) c[i] = int'(cv[i*W +: W]);
`endif
    reload = 1'b0;
    if (!rst) begin
      m_count = 0; m_dir = 1'b1; m_done = 1'b0; m_zero = 1'b0; m_top = 1'b0;
      m_pwm = inv;
      m_per = 0;
      for (int i = 0; i < NUM_CH; i++) m_cmp[i] = 0;
    end else if (clr) begin
      m_count = 0; m_dir = 1'b1; m_done = 1'b0; m_zero = 1'b0; m_top = 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        m_pwm[i] = (int'(cv[i*W +: W]) > 0) ^ inv[i];
      reload = 1'b1;
    end else begin
      m_zero = 1'b0;
      m_top  = 1'b0;
      reload = m_done;
      if (en && !m_done) begin
        zev  = 1'b0;
        ndir = 1'b1;
        if (!ud) begin
          // Sawtooth: 0..P then back to 0.
          if (m_count >= p) begin nxt = 0; zev = 1'b1; end
          else nxt = m_count + 1;
        end else if (m_dir) begin
          // Rising half of the triangle.
          if (p == 0) begin nxt = 0; zev = 1'b1; end
          else if (m_count < p) nxt = m_count + 1;
          else begin
            nxt = m_count - 1;
            if (nxt == 0) zev = 1'b1;
            else ndir = 1'b0;
          end
        end else begin
          // Falling half: arriving at 0 ends the period.
          nxt = m_count - 1;
          if (nxt <= 0) begin nxt = 0; zev = 1'b1; end
          else ndir = 1'b0;
        end
        m_count = nxt;
        m_dir   = ndir;
        m_zero  = zev;
        m_top   = (nxt == p);
        m_done  = zev && os;
        for (int i = 0; i < NUM_CH; i++) m_pwm[i] = (nxt < c[i]) ^ inv[i];
        reload = zev;
      end
    end
    if (reload) begin
      m_per = int'(per);
      for (int i = 0; i < NUM_CH; i++) m_cmp[i] = int'(cv[i*W +: W]);
    end
  endtask

  function automatic logic [EW-1:0] model_vec();
    logic [W-1:0] c;
    c = W'(m_count);
    return {c, m_dir, m_zero, m_top, m_done, m_pwm};
  endfunction

  // ---------------- driver ----------------
  logic                cur_ud = 1'b0;
  logic                cur_os = 1'b0;
  logic [W-1:0]        cur_per = '0;
  logic [NUM_CH*W-1:0] cur_cmp = '0;
  logic [NUM_CH-1:0]   cur_inv = '0;

  task automatic drive(input logic rst, input logic clr, input logic en);
    @(negedge clk);
    n_rst = rst; clear = clr; count_enable = en;
    up_down = cur_ud; one_shot = cur_os; period = cur_per;
    cmp = cur_cmp; invert = cur_inv;
    model_step(rst, clr, en, cur_ud, cur_os, cur_per, cur_cmp, cur_inv);
    exp_q.push_back(model_vec());
  endtask

  task automatic tick(input int n, input logic en);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, en);
  endtask

  task automatic do_clear();
    drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [NUM_CH*W-1:0] pack_cmp(input int c0, input int c1,
                                                   input int c2, input int c3);
    logic [W-1:0] a, b, c, d;
    a = W'(c0); b = W'(c1); c = W'(c2); d = W'(c3);
    return {d, c, b, a};
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EW-1:0] exp_v;
    logic [EW-1:0] act_v;
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {count_out, dir_up, zero_flag, top_flag, done, pwm_out};
        checks++;
        if (act_v === exp_v) passes++;
        else begin
          fails++;
          $display("FAIL cycle_%0d: got count=%0d dir=%b zero=%b top=%b done=%b pwm=%b, expected count=%0d dir=%b zero=%b top=%b done=%b pwm=%b",
                   cyc, act_v[EW-1 -: W], act_v[NUM_CH+3], act_v[NUM_CH+2],
                   act_v[NUM_CH+1], act_v[NUM_CH], act_v[NUM_CH-1:0],
                   exp_v[EW-1 -: W], exp_v[NUM_CH+3], exp_v[NUM_CH+2],
                   exp_v[NUM_CH+1], exp_v[NUM_CH], exp_v[NUM_CH-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int r;
    for (int i = 0; i < NUM_CH; i++) m_cmp[i] = 0;

    // Reset state.
    cur_inv = 4'b0000;
    do_reset();
    do_reset();

    // Sawtooth P=3; ch1 cmp 0 (never high), ch2 cmp 5 > P (always high).
    cur_ud = 1'b0; cur_os = 1'b0; cur_per = 8'd3;
    cur_cmp = pack_cmp(2, 0, 5, 1);
    tick(2, 1'b1);          // settle live values into any shadow copy
    do_clear();
    tick(10, 1'b1);

    // Triangle P=3.
    cur_ud = 1'b1;
    do_clear();
    tick(8, 1'b1);

    // Enable low holds everything, flags drop.
    tick(3, 1'b0);
    tick(2, 1'b1);

    // One-shot sawtooth P=2, then clear and resume.
    cur_ud = 1'b0; cur_os = 1'b1; cur_per = 8'd2;
    do_clear();
    tick(7, 1'b1);
    do_clear();
    tick(2, 1'b1);
    cur_os = 1'b0;

    // Lower the period mid-run at count 4.
    cur_per = 8'd7;
    do_clear();
    do_clear();
    tick(4, 1'b1);
    cur_per = 8'd2;
    tick(8, 1'b1);

    // Reset mid-run at count 5 with inverted outputs.
    cur_per = 8'd10;
    do_clear();
    tick(5, 1'b1);
    cur_inv = 4'b1111;
    do_reset();
    tick(3, 1'b1);

    // Clear together with enable at count 3.
    do_clear();
    tick(3, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    tick(2, 1'b1);

    // Degenerate triangles: P=0 and P=1.
    cur_ud = 1'b1; cur_per = 8'd0; cur_inv = 4'b0101;
    do_clear();
    tick(4, 1'b1);
    cur_per = 8'd1;
    do_clear();
    tick(5, 1'b1);

    // Random mix of modes, periods, compares and control.
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 24) == 0) cur_per = W'($urandom_range(0, 12));
      if ($urandom_range(0, 14) == 0)
        cur_cmp = pack_cmp($urandom_range(0, 14), $urandom_range(0, 14),
                           $urandom_range(0, 14), $urandom_range(0, 14));
      if ($urandom_range(0, 39) == 0) cur_ud = ~cur_ud;
      if ($urandom_range(0, 49) == 0) cur_os = ~cur_os;
      if ($urandom_range(0, 59) == 0) cur_inv = NUM_CH'($urandom_range(0, 15));
      if (r < 1) do_reset();
      else if (r < 6) drive(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      else tick(1, 1'($urandom_range(0, 3) != 0));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
